// File: rtl/miniRV_pkg.sv
// Shared request/response types, grant encoding and address helper for the
// miniRV memory subsystem.
package miniRV_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_D
  } grant_e;

  function automatic logic inRange(input logic [31:0] addr, input logic [31:0] limit);
    return addr < limit;
  endfunction

endpackage

// File: rtl/ram_arbiter_rsp_slot.sv
// One-entry response register with a valid/ready output handshake; free_o
// says a new response may be loaded on the coming edge.
module rsp_slot
  import miniRV_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic        err_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic        free_o,
  output logic [31:0] data_o,
  output logic        err_o
);

  logic valid_q;
  rsp_t rsp_q;
  rsp_t rsp_d;

  assign rsp_d = '{data: data_i, err: err_i};

  // A reload on the same edge as the consumer's ready keeps the slot full,
  // giving one response per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      rsp_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      rsp_q   <= rsp_d;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign free_o  = !valid_q || ready_i;
  assign data_o  = rsp_q.data;
  assign err_o   = rsp_q.err;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between a read-only fetch port and a read/write data
// port; data has priority, but fetch wins after STARVE_MAX data grants in a row.
module ram_arbiter
  import miniRV_pkg::*;
#(
  parameter int unsigned BYTES      = 16000000,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid_i,
  output logic        if_ready_o,
  input  logic [31:0] if_addr_i,
  output logic        if_rsp_valid_o,
  input  logic        if_rsp_ready_i,
  output logic [31:0] if_rsp_data_o,
  output logic        if_rsp_err_o,
  input  logic        d_valid_i,
  output logic        d_ready_o,
  input  logic [31:0] d_addr_i,
  input  logic        d_wen_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_wstrb_i,
  output logic        d_rsp_valid_o,
  input  logic        d_rsp_ready_i,
  output logic [31:0] d_rsp_data_o,
  output logic        d_rsp_err_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_wen_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_wstrb_o,
  input  logic [31:0] ram_read_data_i
);

  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic             ifFree, dFree;
  logic             ifElig, dElig;
  logic             winInRange;
  grant_e           grant;
  req_t             winReq;
  rsp_t             rspLoad;
  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;

  assign ifElig = if_valid_i && ifFree;
  assign dElig  = d_valid_i && dFree;

  // Reset is asynchronous, so it also masks the combinational grant directly.
  always_comb begin
    grant = GNT_NONE;
    if (reset) begin
      grant = GNT_NONE;
    end else if (dElig && !(ifElig && starveCnt_q == STARVE_LIM)) begin
      grant = GNT_D;
    end else if (ifElig) begin
      grant = GNT_IF;
    end
  end

  always_comb begin
    winReq = '{addr: d_addr_i, wen: d_wen_i, wdata: d_wdata_i, wstrb: d_wstrb_i};
    case (grant)
      GNT_IF: begin
        winReq.addr = if_addr_i;
        winReq.wen  = 1'b0;
      end
      GNT_D: begin
      end
      default: begin
        winReq.wen   = 1'b0;
        winReq.wstrb = '0;
      end
    endcase
  end

  assign winInRange  = inRange(winReq.addr, BYTES);
  assign ram_addr_o  = winReq.addr;
  assign ram_wen_o   = winReq.wen && winInRange;
  assign ram_wdata_o = winReq.wdata;
  assign ram_wstrb_o = winReq.wstrb;

  assign if_ready_o = (grant == GNT_IF);
  assign d_ready_o  = (grant == GNT_D);

  // Writes and out-of-range accesses answer with zero data.
  assign rspLoad = '{data: (winInRange && !winReq.wen) ? ram_read_data_i : 32'h0,
                     err:  !winInRange};

  // The starvation count only tracks data wins while fetch is actually waiting.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!ifElig || grant == GNT_IF) begin
      starveCnt_d = '0;
    end else if (grant == GNT_D && starveCnt_q != STARVE_LIM) begin
      starveCnt_d = starveCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end

  rsp_slot u_if_slot (
    .clk     (clk),
    .reset   (reset),
    .load_i  (grant == GNT_IF),
    .data_i  (rspLoad.data),
    .err_i   (rspLoad.err),
    .ready_i (if_rsp_ready_i),
    .valid_o (if_rsp_valid_o),
    .free_o  (ifFree),
    .data_o  (if_rsp_data_o),
    .err_o   (if_rsp_err_o)
  );

  rsp_slot u_d_slot (
    .clk     (clk),
    .reset   (reset),
    .load_i  (grant == GNT_D),
    .data_i  (rspLoad.data),
    .err_i   (rspLoad.err),
    .ready_i (d_rsp_ready_i),
    .valid_o (d_rsp_valid_o),
    .free_o  (dFree),
    .data_o  (d_rsp_data_o),
    .err_o   (d_rsp_err_o)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a word-array RAM sits on the RAM port and a
// separate reference memory predicts every response from the arbitration rules.
module tb_ram_arbiter;

  localparam int unsigned BYTES      = 1024;
  localparam int unsigned STARVE_MAX = 4;
  localparam int          WORDS      = 256;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          issued;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ifValid, ifReady, ifRspValid, ifRspReady, ifRspErr;
  logic [31:0] ifAddr, ifRspData;
  logic        dValid, dReady, dWen, dRspValid, dRspReady, dRspErr;
  logic [31:0] dAddr, dWdata, dRspData;
  logic [3:0]  dWstrb;
  logic [31:0] ramAddr, ramWdata, ramReadData;
  logic        ramWen;
  logic [3:0]  ramWstrb;

  logic [31:0] envMem   [WORDS];
  logic [31:0] modelMem [WORDS];
  exp_t        ifQ[$];
  exp_t        dQ[$];
  int          compared    = 0;
  int          mismatched  = 0;
  int          cycleNow    = 0;
  int          starveModel = 0;

  logic        pendWen;
  logic [31:0] pendAddr, pendData;
  logic [3:0]  pendStrb;

  ram_arbiter #(.BYTES(BYTES), .STARVE_MAX(STARVE_MAX)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_valid_i      (ifValid),
    .if_ready_o      (ifReady),
    .if_addr_i       (ifAddr),
    .if_rsp_valid_o  (ifRspValid),
    .if_rsp_ready_i  (ifRspReady),
    .if_rsp_data_o   (ifRspData),
    .if_rsp_err_o    (ifRspErr),
    .d_valid_i       (dValid),
    .d_ready_o       (dReady),
    .d_addr_i        (dAddr),
    .d_wen_i         (dWen),
    .d_wdata_i       (dWdata),
    .d_wstrb_i       (dWstrb),
    .d_rsp_valid_o   (dRspValid),
    .d_rsp_ready_i   (dRspReady),
    .d_rsp_data_o    (dRspData),
    .d_rsp_err_o     (dRspErr),
    .ram_addr_o      (ramAddr),
    .ram_wen_o       (ramWen),
    .ram_wdata_o     (ramWdata),
    .ram_wstrb_o     (ramWstrb),
    .ram_read_data_i (ramReadData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleNow <= cycleNow + 1;

  assign ramReadData = envMem[ramAddr[9:2]];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycleNow);
    end
  endtask

  // The RAM write the DUT launched on the last edge lands in the environment memory.
  task automatic commitEnvWrite();
    if (pendWen) begin
      for (int b = 0; b < 4; b++)
        if (pendStrb[b]) envMem[pendAddr[9:2]][8*b +: 8] = pendData[8*b +: 8];
    end
    pendWen = 1'b0;
  endtask

  task automatic applyStimulus(input logic ifV, input logic [31:0] ifA, input logic ifRR,
                               input logic dV, input logic [31:0] dA, input logic dW,
                               input logic [31:0] dWd, input logic [3:0] dWs, input logic dRR);
    logic        ifElig, dElig, ifOob, dOob;
    int          expGrant;
    exp_t        e;
    logic [31:0] merged;
    @(negedge clk);
    commitEnvWrite();
    ifValid = ifV; ifAddr = ifA; ifRspReady = ifRR;
    dValid = dV; dAddr = dA; dWen = dW; dWdata = dWd; dWstrb = dWs; dRspReady = dRR;
    #1;
    ifElig = ifV && (ifQ.size() == 0 || ifRR);
    dElig  = dV && (dQ.size() == 0 || dRR);
    if (dElig && !(ifElig && starveModel == STARVE_MAX)) expGrant = 2;
    else if (ifElig) expGrant = 1;
    else expGrant = 0;
    ifOob = ifA >= BYTES;
    dOob  = dA >= BYTES;
    checkOutput("if_ready", 32'(ifReady), 32'(expGrant == 1));
    checkOutput("d_ready", 32'(dReady), 32'(expGrant == 2));
    checkOutput("ram_wen", 32'(ramWen), 32'(expGrant == 2 && dW && !dOob));
    if (expGrant == 0) checkOutput("ram_wstrb_idle", 32'(ramWstrb), 32'h0);
    if (expGrant == 1) begin
      checkOutput("ram_addr_if", ramAddr, ifA);
      e.data = ifOob ? 32'h0 : modelMem[ifA[9:2]];
      e.err = ifOob;
      e.issued = cycleNow;
      ifQ.push_back(e);
    end
    if (expGrant == 2) begin
      checkOutput("ram_addr_d", ramAddr, dA);
      if (dW) begin
        if (!dOob) begin
          merged = modelMem[dA[9:2]];
          for (int b = 0; b < 4; b++)
            if (dWs[b]) merged[8*b +: 8] = dWd[8*b +: 8];
          modelMem[dA[9:2]] = merged;
        end
        e.data = 32'h0;
      end else begin
        e.data = dOob ? 32'h0 : modelMem[dA[9:2]];
      end
      e.err = dOob;
      e.issued = cycleNow;
      dQ.push_back(e);
    end
    if (!ifElig || expGrant == 1) starveModel = 0;
    else if (expGrant == 2 && starveModel < STARVE_MAX) starveModel++;
    pendWen = ramWen; pendAddr = ramAddr; pendData = ramWdata; pendStrb = ramWstrb;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1);
  endtask

  task automatic doReset(input logic busy);
    @(negedge clk);
    commitEnvWrite();
    reset = 1'b1;
    ifValid = busy; ifAddr = 32'h300; ifRspReady = 1'b0;
    dValid = busy; dAddr = 32'h304; dWen = busy; dWdata = 32'h5A5A5A5A; dWstrb = 4'hF;
    dRspReady = 1'b0;
    ifQ.delete();
    dQ.delete();
    starveModel = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("rst_if_ready", 32'(ifReady), 32'h0);
      checkOutput("rst_d_ready", 32'(dReady), 32'h0);
      checkOutput("rst_ram_wen", 32'(ramWen), 32'h0);
      checkOutput("rst_ram_wstrb", 32'(ramWstrb), 32'h0);
      @(negedge clk);
    end
    reset = 1'b0;
    ifValid = 1'b0; dValid = 1'b0; dWen = 1'b0; ifRspReady = 1'b1; dRspReady = 1'b1;
    #1;
    checkOutput("rst_if_rsp_valid", 32'(ifRspValid), 32'h0);
    checkOutput("rst_d_rsp_valid", 32'(dRspValid), 32'h0);
    checkOutput("rst_if_rsp_data", ifRspData, 32'h0);
    checkOutput("rst_d_rsp_data", dRspData, 32'h0);
    checkOutput("rst_d_rsp_err", 32'(dRspErr), 32'h0);
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 9))
      0:       return 32'(BYTES + 4 * $urandom_range(0, 15));
      1:       return 32'hFFFF_FFFC;
      default: return 32'(32'h300 + 4 * $urandom_range(0, 15));
    endcase
  endfunction

  // Monitor: compares every presented response against the head of its queue.
  initial begin
    logic expV;
    forever begin
      @(negedge clk);
      #2;
      expV = ifQ.size() > 0 && ifQ[0].issued < cycleNow;
      checkOutput("if_rsp_valid", 32'(ifRspValid), 32'(expV));
      if (ifRspValid && expV) begin
        checkOutput("if_rsp_data", ifRspData, ifQ[0].data);
        checkOutput("if_rsp_err", 32'(ifRspErr), 32'(ifQ[0].err));
        if (ifRspReady) void'(ifQ.pop_front());
      end
      expV = dQ.size() > 0 && dQ[0].issued < cycleNow;
      checkOutput("d_rsp_valid", 32'(dRspValid), 32'(expV));
      if (dRspValid && expV) begin
        checkOutput("d_rsp_data", dRspData, dQ[0].data);
        checkOutput("d_rsp_err", 32'(dRspErr), 32'(dQ[0].err));
        if (dRspReady) void'(dQ.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    ifValid = 1'b0; ifAddr = 32'h0; ifRspReady = 1'b1;
    dValid = 1'b0; dAddr = 32'h0; dWen = 1'b0; dWdata = 32'h0; dWstrb = 4'h0; dRspReady = 1'b1;
    pendWen = 1'b0; pendAddr = 32'h0; pendData = 32'h0; pendStrb = 4'h0;
    for (int i = 0; i < WORDS; i++) begin
      envMem[i] = $urandom;
      modelMem[i] = envMem[i];
    end
    envMem[32'h100 >> 2] = 32'hDEADBEEF; modelMem[32'h100 >> 2] = 32'hDEADBEEF;
    envMem[32'h200 >> 2] = 32'h0;        modelMem[32'h200 >> 2] = 32'h0;

    doReset(1'b0);
    idleCycle();

    // Single fetch with a known word.
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1);
    checkOutput("fetch_if_ready", 32'(ifReady), 32'h1);
    idleCycle();
    checkOutput("fetch_rsp_valid", 32'(ifRspValid), 32'h1);
    checkOutput("fetch_rsp_data", ifRspData, 32'hDEADBEEF);
    checkOutput("fetch_rsp_err", 32'(ifRspErr), 32'h0);

    // Strobed write then read-back.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b1, 32'hAABBCCDD, 4'b0101, 1'b1);
    idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 4'h0, 1'b1);
    idleCycle();
    checkOutput("wr_rd_data", dRspData, 32'h00BB00DD);

    // Out-of-range write.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'(BYTES), 1'b1, 32'h12345678, 4'hF, 1'b1);
    checkOutput("oob_ram_wen", 32'(ramWen), 32'h0);
    idleCycle();
    checkOutput("oob_rsp_err", 32'(dRspErr), 32'h1);
    checkOutput("oob_rsp_data", dRspData, 32'h0);

    // Contention: D,D,D,D,IF repeating.
    idleCycle();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 32'(32'h300 + 4 * (i % 16)), 1'b1, 1'b1, 32'(32'h340 + 4 * (i % 8)),
                    1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1'b1);
      checkOutput("contention_pattern", 32'(dReady), 32'(i % 5 != 4));
    end

    // Data backpressure: fetch keeps flowing while the data slot is stuck.
    idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h304, 1'b0, 32'h0, 4'h0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 32'(32'h300 + 4 * k), 1'b1, 1'b1, 32'h308, 1'b0, 32'h0, 4'h0, 1'b0);
      checkOutput("stall_if_ready", 32'(ifReady), 32'h1);
      checkOutput("stall_d_ready", 32'(dReady), 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1);
    idleCycle();

    // Reset with both response slots full.
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 32'h304, 1'b0, 32'h0, 4'h0, 1'b0);
    applyStimulus(1'b1, 32'h308, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
    doReset(1'b1);
    idleCycle();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), randAddr(), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) != 0), randAddr(), 1'($urandom_range(0, 1)),
                    $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end

    for (int k = 0; k < 10; k++) begin
      idleCycle();
      #2;
      if (ifQ.size() == 0 && dQ.size() == 0) break;
    end
    checkOutput("drain_outstanding", 32'(ifQ.size() + dQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter BYTES, default 16000000: size of the shared byte-addressed RAM.
REQ-002 Parameter STARVE_MAX, default 4: maximum consecutive data-port grants while a fetch request waits.
REQ-003 clk  input  1  clock; all state updates on the posedge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 if_valid / if_ready  input / output  1 / 1  fetch request handshake; fetch port is read-only.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_rsp_valid / if_rsp_ready / if_rsp_data / if_rsp_err  out / in / out / out  1 / 1 / 32 / 1  fetch response.
REQ-008 d_valid / d_ready  input / output  1 / 1  data request handshake.
REQ-009 d_addr / d_wen / d_wdata / d_wstrb  input  32 / 1 / 32 / 4  data byte address, write enable, write data, byte strobes.
REQ-010 d_rsp_valid / d_rsp_ready / d_rsp_data / d_rsp_err  out / in / out / out  1 / 1 / 32 / 1  data response; issued for reads and writes.
REQ-011 ram_addr / ram_wen / ram_wdata / ram_wstrb  output  32 / 1 / 32 / 4  drive the single RAM port.
REQ-012 ram_read_data  input  32  combinational RAM read data for ram_addr.

Function
REQ-013 A port is eligible when its valid is high and its response slot is empty, or is being emptied this cycle (rsp_valid && rsp_ready).
REQ-014 At most one of if_ready and d_ready is high in any cycle; ready is combinational from eligibility and the arbitration state, and never depends on the same port's valid falling.
REQ-015 Priority: data wins over fetch, except when starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-016 starve_cnt increments (saturating at STARVE_MAX) on each data grant while fetch is eligible; it clears on every fetch grant and whenever fetch is not eligible.
REQ-017 In a grant cycle, ram_* carries the winner's address; ram_wen = d_wen && grant_d && (d_addr < BYTES); ram_wstrb and ram_wdata pass through. With no grant, ram_wen = 0 and ram_wstrb = 0.
REQ-018 On the granting edge, the winner's response slot loads rsp_data = ram_read_data (reads) or 0 (writes), and rsp_err = (addr >= BYTES); rsp_valid rises in the next cycle. Latency is one cycle.
REQ-019 For an out-of-range request: no RAM write occurs, rsp_data = 0, rsp_err = 1.
REQ-020 rsp_valid and its data/err hold stable until rsp_ready is sampled high; the slot clears on that edge unless it is reloaded on the same edge (back-to-back throughput of 1 per cycle per port).
REQ-021 A port with a full slot and rsp_ready low is not granted; the other port may still be granted.
REQ-022 Request inputs need only be valid in the handshake cycle; the block does not register them.

Reset
REQ-023 Reset clears starve_cnt, both rsp_valid, rsp_data and rsp_err to 0; it forces if_ready, d_ready, ram_wen and ram_wstrb low while asserted.
REQ-024 A reset asserted mid-response discards the pending responses; no grant occurs in the first cycle after deassertion unless a valid is present.

Structure
REQ-025 The shared package miniRV_pkg holds the request and response struct typedefs (addr/wen/wdata/wstrb; data/err) and the grant enum (GNT_NONE, GNT_IF, GNT_D).
REQ-026 One sub-module, rsp_slot, is instantiated twice, once per port: a one-entry response register with valid/ready.

Verification
REQ-027 Fetch only: if_addr=0x100 with RAM word 0xDEADBEEF at that address, if_rsp_ready=1 -> if_ready in the same cycle; if_rsp_valid and if_rsp_data=0xDEADBEEF next cycle; if_rsp_err=0.
REQ-028 Write then read: d write 0x200, wdata=0xAABBCCDD, wstrb=4'b0101, over initial 0 -> following read returns 0x00BB00DD.
REQ-029 Contention: both ports valid every cycle with STARVE_MAX=4 -> grant pattern D,D,D,D,IF repeating; starve_cnt is never above 4.
REQ-030 Backpressure: d_rsp_ready=0 after one data read -> d_ready low and d_rsp_data stable for 10 cycles; fetch is granted during the stall; d_rsp_ready=1 releases the slot.
REQ-031 Out of range: d write to BYTES with wstrb=4'hF -> ram_wen=0, d_rsp_err=1, d_rsp_data=0.
REQ-032 Reset with both slots full -> all rsp_valid=0 next cycle; no ram_wen pulse occurs during reset.
